// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the 4-digit display scanner.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a} with dp off.
package display_scan_ctrl_pkg;

    localparam int NUM_W = 11;
    localparam int BCD_W = 16;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } conv_state_t;

    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

    // Shift-add-3 correction: any nibble >= 5 would overflow past 9 on the next shift.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < 4; i++) begin
            if (res[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
            end else begin
                res[i*4 +: 4] = res[i*4 +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_bin2bcd.sv
// Serial binary-to-BCD converter: one shift-add-3 step per cycle, then a one-cycle
// commit where the finished BCD word is offered on bcd with valid high.
module bin2bcd_seq
    import display_scan_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] number,
    output logic             busy,
    output logic [BCD_W-1:0] bcd,
    output logic             valid
);

    conv_state_t      state_r;
    conv_state_t      state_s;
    logic [NUM_W-1:0] bin_r;
    logic [BCD_W-1:0] bcd_r;
    logic [3:0]       bit_cnt_r;
    logic             busy_r;
    logic [BCD_W-1:0] bcd_adj_s;

    // Next-state decode; start is only honoured from IDLE.
    always_comb begin
        state_s   = state_r;
        bcd_adj_s = bcd_adjust(bcd_r);
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_CONV;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CONV: begin
                if (bit_cnt_r == 4'(NUM_W - 1)) begin
                    state_s = S_COMMIT;
                end else begin
                    state_s = S_CONV;
                end
            end
            S_COMMIT: state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // State register plus conversion datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            bin_r     <= '0;
            bcd_r     <= '0;
            bit_cnt_r <= 4'd0;
            busy_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != S_IDLE);
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        bin_r     <= number;
                        bcd_r     <= '0;
                        bit_cnt_r <= 4'd0;
                    end
                end
                S_CONV: begin
                    bcd_r     <= {bcd_adj_s[BCD_W-2:0], bin_r[NUM_W-1]};
                    bin_r     <= {bin_r[NUM_W-2:0], 1'b0};
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end
                default: begin
                    bin_r <= bin_r;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign bcd   = bcd_r;
    assign valid = (state_r == S_COMMIT);

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit 7-segment sequencer: serial BCD conversion of a loaded value, then
// continuous multiplexed scan with optional leading-zero blanking.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NUM_W-1:0] number,
    input  logic             load,
    input  logic             blank_lz,
    output logic             busy,
    output logic [3:0]       n_cnt,
    output logic [7:0]       seg
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [BCD_W-1:0] bcd_s;
    logic             valid_s;
    logic [BCD_W-1:0] disp_r;
    logic [PW-1:0]    presc_r;
    logic [1:0]       idx_r;
    logic [1:0]       idx_s;
    logic             terminal_s;
    logic [3:0]       digit_s;
    logic             blank_s;
    logic [7:0]       seg_s;
    logic [3:0]       n_cnt_r;
    logic [7:0]       seg_r;

    bin2bcd_seq u_bin2bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (load),
        .number (number),
        .busy   (busy),
        .bcd    (bcd_s),
        .valid  (valid_s)
    );

    // Pins are driven from the upcoming digit index so anode and segments switch together.
    always_comb begin
        terminal_s = (presc_r == PW'(CLK_DIV - 1));
        idx_s      = idx_r;
        digit_s    = disp_r[3:0];
        blank_s    = 1'b0;
        if (terminal_s) begin
            idx_s = idx_r + 2'd1;
        end else begin
            idx_s = idx_r;
        end
        case (idx_s)
            2'd0: begin
                digit_s = disp_r[3:0];
                blank_s = 1'b0;
            end
            2'd1: begin
                digit_s = disp_r[7:4];
                blank_s = (disp_r[15:4] == 12'd0);
            end
            2'd2: begin
                digit_s = disp_r[11:8];
                blank_s = (disp_r[15:8] == 8'd0);
            end
            2'd3: begin
                digit_s = disp_r[15:12];
                blank_s = (disp_r[15:12] == 4'd0);
            end
            default: begin
                digit_s = 4'd0;
                blank_s = 1'b0;
            end
        endcase
        if (blank_lz && blank_s) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = seg_decode(digit_s) | 8'h80;
        end
    end

    // Prescaler, digit index, display latch and registered pin drivers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_r <= '0;
            idx_r   <= 2'd0;
            disp_r  <= '0;
            n_cnt_r <= 4'b1110;
            seg_r   <= SEG_0;
        end else begin
            presc_r <= terminal_s ? '0 : presc_r + PW'(1);
            idx_r   <= idx_s;
            if (valid_s) begin
                disp_r <= bcd_s;
            end
            n_cnt_r <= ~(4'b0001 << idx_s);
            seg_r   <= seg_s;
        end
    end

    assign n_cnt = n_cnt_r;
    assign seg   = seg_r;

endmodule
